program_memory: RTL and testbench

PROGRAM_MEMORY -- requirements
Module: program_memory

---
 rtl/program_memory_pkg.sv | 32 +++
 rtl/sync_ram.sv | 30 +++
 rtl/program_memory.sv | 196 +++++++++++++++++++
 tb/tb_program_memory.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_memory_pkg.sv
// Shared CPU definitions: program-memory FSM states, the NOP word and the
// opcode byte values that live in the top byte of every instruction.
package program_memory_pkg;

    // Program-memory controller states.
    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_LOAD  = 2'd2,
        ST_FLUSH = 2'd3
    } pm_state_e;

    // All-zero instruction; sliced down to the configured instruction width.
    localparam logic [63:0] NOP_WORD = 64'h0;

    // Opcode byte values (MSB of an instruction word).
    localparam logic [7:0] OPC_NOP   = 8'h00;
    localparam logic [7:0] OPC_LOAD  = 8'h01;
    localparam logic [7:0] OPC_STORE = 8'h02;
    localparam logic [7:0] OPC_ADD   = 8'h10;
    localparam logic [7:0] OPC_SUB   = 8'h11;
    localparam logic [7:0] OPC_JUMP  = 8'h20;
    localparam logic [7:0] OPC_BRZ   = 8'h21;
    localparam logic [7:0] OPC_HALT  = 8'hFF;

    // Number of bit positions a partially assembled word must move left so
    // that its first byte lands in the top byte (remaining bytes become zero).
    function automatic logic [6:0] pad_shift(input int nbytes, input int held);
        return 7'((nbytes - held) * 32'sd8);
    endfunction

endpackage

// File: rtl/sync_ram.sv
// Single-port-write, registered-read storage array intended for block RAM.
// A read of the address being written returns the previous contents.
module sync_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 32'sd1 <<< ADDR_W;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rdata_r;

    // Write port and registered read port; non-blocking update gives read-before-write.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
        rdata_r <= mem_r[raddr];
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/program_memory.sv
// Instruction memory with a byte-serial loader. After reset the whole array
// is cleared to NOP, then programs are streamed in MSB-first, assembled into
// words and written sequentially from word 0. Fetches are blanked while busy.
module program_memory
    import program_memory_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] instruction,
    output logic              busy,
    input  logic              load_start,
    input  logic [7:0]        load_byte,
    input  logic              load_valid,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_error,
    output logic [ADDR_W:0]   word_count
);

    localparam int DEPTH  = 32'sd1 <<< ADDR_W;
    localparam int NBYTES = DATA_W / 32'sd8;
    localparam int IDX_W  = $clog2(NBYTES + 32'sd1);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 32'sd1);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(1'b1);
    localparam logic [ADDR_W:0]   PTR_STEP  = (ADDR_W + 1)'(1'b1);
    localparam logic [IDX_W-1:0]  LAST_BYTE = IDX_W'(NBYTES - 32'sd1);
    localparam logic [IDX_W-1:0]  BYTE_STEP = IDX_W'(1'b1);
    localparam logic [DATA_W-1:0] NOP       = NOP_WORD[DATA_W-1:0];

    pm_state_e         state_r;
    logic [ADDR_W-1:0] clear_addr_r;
    logic [ADDR_W:0]   wr_ptr_r;
    logic [IDX_W-1:0]  byte_cnt_r;
    logic [DATA_W-1:0] asm_r;
    logic              busy_r;
    logic              load_ready_r;
    logic              load_error_r;
    logic [ADDR_W:0]   word_count_r;

    logic [DATA_W+7:0] shift_cat_s;
    logic [DATA_W-1:0] assembled_s;
    logic [DATA_W-1:0] flush_word_s;
    logic              accept_s;
    logic              word_done_s;
    logic              in_range_s;
    logic [ADDR_W:0]   ptr_next_s;
    logic              ram_we_s;
    logic [ADDR_W-1:0] ram_waddr_s;
    logic [DATA_W-1:0] ram_wdata_s;
    logic [DATA_W-1:0] ram_rdata_s;

    // Byte acceptance, word assembly and write-pointer arithmetic.
    always_comb begin
        shift_cat_s  = {asm_r, load_byte};
        assembled_s  = shift_cat_s[DATA_W-1:0];
        flush_word_s = asm_r << pad_shift(NBYTES, int'(byte_cnt_r));
        accept_s     = (state_r == ST_LOAD) && load_valid;
        word_done_s  = accept_s && (byte_cnt_r == LAST_BYTE);
        // The pointer saturates at DEPTH, so its top bit flags "array full".
        in_range_s   = ~wr_ptr_r[ADDR_W];
        if (in_range_s) begin
            ptr_next_s = wr_ptr_r + PTR_STEP;
        end else begin
            ptr_next_s = wr_ptr_r;
        end
    end

    // Storage write mux: clear sweep, completed words, or the padded flush word.
    always_comb begin
        ram_we_s    = 1'b0;
        ram_waddr_s = wr_ptr_r[ADDR_W-1:0];
        ram_wdata_s = assembled_s;
        if (reset) begin
            ram_we_s = 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    ram_we_s    = 1'b1;
                    ram_waddr_s = clear_addr_r;
                    ram_wdata_s = NOP;
                end
                ST_LOAD: begin
                    ram_we_s = word_done_s && in_range_s;
                end
                ST_FLUSH: begin
                    ram_we_s    = in_range_s;
                    ram_wdata_s = flush_word_s;
                end
                default: begin
                    ram_we_s = 1'b0;
                end
            endcase
        end
    end

    // Controller FSM with its counters and registered status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_CLEAR;
            clear_addr_r <= {ADDR_W{1'b0}};
            wr_ptr_r     <= {(ADDR_W + 1){1'b0}};
            byte_cnt_r   <= {IDX_W{1'b0}};
            asm_r        <= NOP;
            busy_r       <= 1'b1;
            load_ready_r <= 1'b0;
            load_error_r <= 1'b0;
            word_count_r <= {(ADDR_W + 1){1'b0}};
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    clear_addr_r <= clear_addr_r + ADDR_STEP;
                    if (clear_addr_r == LAST_ADDR) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (load_start) begin
                        state_r      <= ST_LOAD;
                        wr_ptr_r     <= {(ADDR_W + 1){1'b0}};
                        byte_cnt_r   <= {IDX_W{1'b0}};
                        asm_r        <= NOP;
                        load_error_r <= 1'b0;
                        word_count_r <= {(ADDR_W + 1){1'b0}};
                        busy_r       <= 1'b1;
                        load_ready_r <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (word_done_s) begin
                        byte_cnt_r <= {IDX_W{1'b0}};
                        asm_r      <= NOP;
                        wr_ptr_r   <= ptr_next_s;
                        if (!in_range_s) begin
                            load_error_r <= 1'b1;
                        end
                        if (load_last) begin
                            state_r      <= ST_IDLE;
                            busy_r       <= 1'b0;
                            load_ready_r <= 1'b0;
                            word_count_r <= ptr_next_s;
                        end
                    end else if (accept_s) begin
                        byte_cnt_r <= byte_cnt_r + BYTE_STEP;
                        asm_r      <= assembled_s;
                        if (load_last) begin
                            state_r      <= ST_FLUSH;
                            load_ready_r <= 1'b0;
                        end
                    end
                end
                ST_FLUSH: begin
                    wr_ptr_r     <= ptr_next_s;
                    byte_cnt_r   <= {IDX_W{1'b0}};
                    asm_r        <= NOP;
                    word_count_r <= ptr_next_s;
                    if (!in_range_s) begin
                        load_error_r <= 1'b1;
                    end
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r      <= ST_CLEAR;
                    clear_addr_r <= {ADDR_W{1'b0}};
                    busy_r       <= 1'b1;
                    load_ready_r <= 1'b0;
                end
            endcase
        end
    end

    sync_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clock (clock),
        .we    (ram_we_s),
        .waddr (ram_waddr_s),
        .wdata (ram_wdata_s),
        .raddr (address),
        .rdata (ram_rdata_s)
    );

    assign instruction = busy_r ? NOP : ram_rdata_s;
    assign busy        = busy_r;
    assign load_ready  = load_ready_r;
    assign load_error  = load_error_r;
    assign word_count  = word_count_r;

endmodule

// File: tb/tb_program_memory.sv
// Bench for program_memory: a 256-word and a 4-word instance driven by
// directed loads, checked every cycle against a byte-stream memory model.
module tb_program_memory;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  address_a;
    logic [31:0] instr_a;
    logic        busy_a, start_a, valid_a, last_a, ready_a, err_a;
    logic [7:0]  byte_a;
    logic [8:0]  wc_a;
    logic [1:0]  address_b;
    logic [31:0] instr_b;
    logic        busy_b, start_b, valid_b, last_b, ready_b, err_b;
    logic [7:0]  byte_b;
    logic [2:0]  wc_b;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    program_memory #(.ADDR_W(8), .DATA_W(32)) dut_a (
        .clock(clock), .reset(reset), .address(address_a), .instruction(instr_a),
        .busy(busy_a), .load_start(start_a), .load_byte(byte_a), .load_valid(valid_a),
        .load_last(last_a), .load_ready(ready_a), .load_error(err_a), .word_count(wc_a));

    program_memory #(.ADDR_W(2), .DATA_W(32)) dut_b (
        .clock(clock), .reset(reset), .address(address_b), .instruction(instr_b),
        .busy(busy_b), .load_start(start_b), .load_byte(byte_b), .load_valid(valid_b),
        .load_last(last_b), .load_ready(ready_b), .load_error(err_b), .word_count(wc_b));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int P_CLR = 0, P_IDLE = 1, P_LOAD = 2, P_FLUSH = 3;
    int          m_depth [2] = '{256, 4};
    logic [31:0] m_mem   [2][256];
    int          m_ph [2], m_clr [2], m_nb [2], m_ptr [2], m_wc [2];
    logic        m_err [2];
    logic        m_seen [2] = '{1'b0, 1'b0};
    logic [31:0] m_word [2];
    logic [31:0] e_instr [2];
    logic        e_busy [2], e_ready [2], e_err [2];
    int          e_wc [2];

    task automatic store(input int w);
        if (m_ptr[w] < m_depth[w]) begin
            m_mem[w][m_ptr[w]] = m_word[w];
            m_ptr[w]++;
        end else begin
            m_err[w] = 1'b1;
        end
        m_word[w] = 32'h0;
        m_nb[w]   = 0;
    endtask

    task automatic step(input int w, input logic rst, input logic st, input logic v,
                        input logic [7:0] b, input logic l, input int addr);
        logic [31:0] rd;
        rd = m_mem[w][addr];
        if (rst) begin
            m_seen[w] = 1'b1; m_ph[w] = P_CLR; m_clr[w] = 0; m_nb[w] = 0;
            m_ptr[w] = 0; m_err[w] = 1'b0; m_wc[w] = 0; m_word[w] = 32'h0;
        end else if (m_seen[w]) begin
            case (m_ph[w])
                P_CLR: begin
                    m_mem[w][m_clr[w]] = 32'h0;
                    m_clr[w]++;
                    if (m_clr[w] == m_depth[w]) m_ph[w] = P_IDLE;
                end
                P_IDLE: if (st) begin
                    m_ph[w] = P_LOAD; m_ptr[w] = 0; m_nb[w] = 0; m_wc[w] = 0;
                    m_err[w] = 1'b0; m_word[w] = 32'h0;
                end
                P_LOAD: if (v) begin
                    m_word[w] = (m_word[w] << 8) | {24'h0, b};
                    m_nb[w]++;
                    if (m_nb[w] == 4) begin
                        store(w);
                        if (l) begin m_wc[w] = m_ptr[w]; m_ph[w] = P_IDLE; end
                    end else if (l) begin
                        m_ph[w] = P_FLUSH;
                    end
                end
                P_FLUSH: begin
                    m_word[w] = m_word[w] << (8 * (4 - m_nb[w]));
                    store(w);
                    m_wc[w] = m_ptr[w];
                    m_ph[w] = P_IDLE;
                end
                default: ;
            endcase
        end
        e_busy[w]  = (m_ph[w] != P_IDLE);
        e_ready[w] = (m_ph[w] == P_LOAD);
        e_instr[w] = e_busy[w] ? 32'h0 : rd;
        e_err[w]   = m_err[w];
        e_wc[w]    = m_wc[w];
    endtask

    // Model advances on every rising edge using the inputs the DUTs sampled.
    initial forever begin
        @(posedge clock);
        step(0, reset, start_a, valid_a, byte_a, last_a, int'(address_a));
        step(1, reset, start_b, valid_b, byte_b, last_b, int'(address_b));
    end

    // Compare process: every falling edge once the model has seen a reset.
    initial forever begin
        @(negedge clock);
        if (m_seen[0]) begin
            chk("a_instr", instr_a, e_instr[0]); chk("a_busy", busy_a, e_busy[0]);
            chk("a_ready", ready_a, e_ready[0]); chk("a_err", err_a, e_err[0]);
            chk("a_wc", wc_a, e_wc[0]);
        end
        if (m_seen[1]) begin
            chk("b_instr", instr_b, e_instr[1]); chk("b_busy", busy_b, e_busy[1]);
            chk("b_ready", ready_b, e_ready[1]); chk("b_err", err_b, e_err[1]);
            chk("b_wc", wc_b, e_wc[1]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int w, input logic s, input logic v, input logic [7:0] b, input logic l);
        if (w == 0) begin start_a = s; valid_a = v; byte_a = b; last_a = l; end
        else begin start_b = s; valid_b = v; byte_b = b; last_b = l; end
    endtask

    function automatic logic busy_of(input int w);
        return (w == 0) ? busy_a : busy_b;
    endfunction

    task automatic load(input int w, input logic [7:0] bytes[$], input int gap);
        drive(w, 1'b1, 1'b0, 8'h00, 1'b0);
        @(negedge clock);
        for (int i = 0; i < bytes.size(); i++) begin
            if (gap != 0 && (i % 2) == 1) begin
                // Invalid cycle carrying junk, a stray last and a stray start.
                drive(w, 1'b1, 1'b0, 8'hEE, 1'b1);
                @(negedge clock);
            end
            drive(w, 1'b0, 1'b1, bytes[i], (i == bytes.size() - 1));
            @(negedge clock);
        end
        drive(w, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic wait_idle(input int w, input string name);
        for (int i = 0; i < 64; i++) begin
            if (!busy_of(w)) break;
            @(negedge clock);
        end
        chk(name, busy_of(w), 1'b0);
    endtask

    task automatic count_clear(output int n);
        n = 1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock);
            if (busy_a) n++;
            else break;
        end
    endtask

    task automatic fetch(input int w, input int a, output logic [31:0] d);
        if (w == 0) address_a = 8'(a); else address_b = 2'(a);
        @(negedge clock);
        d = (w == 0) ? instr_a : instr_b;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int          n;
        logic [31:0] d;
        logic [7:0]  q[$];
        reset = 1'b1; address_a = 8'h00; address_b = 2'b00;
        drive(0, 1'b0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 1'b0, 8'h00, 1'b0);
        repeat (3) @(negedge clock);
        chk("rst_busy", busy_a, 1'b1); chk("rst_ready", ready_a, 1'b0);
        chk("rst_instr", instr_a, 32'h0); chk("rst_err", err_a, 1'b0);
        chk("rst_wc", wc_a, 9'd0);
        reset = 1'b0;
        count_clear(n);
        chk("clear_cycles", n, 256);
        for (int a = 0; a < 256; a++) begin
            fetch(0, a, d);
            chk("clear_zero", d, 32'h0);
        end

        // Two full words.
        q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        load(0, q, 0);
        wait_idle(0, "load1_idle");
        chk("load1_wc", wc_a, 9'd2); chk("load1_err", err_a, 1'b0);
        fetch(0, 0, d); chk("load1_w0", d, 32'h12345678);
        fetch(0, 1, d); chk("load1_w1", d, 32'h9ABCDEF0);

        // Partial word, flushed; address held on the word being rewritten.
        address_a = 8'h00;
        q = '{8'hAA, 8'hBB, 8'hCC};
        load(0, q, 0);
        chk("flush_busy", busy_a, 1'b1); chk("flush_ready", ready_a, 1'b0);
        wait_idle(0, "load2_idle");
        chk("rbw_old", instr_a, 32'h12345678);
        @(negedge clock);
        chk("flush_w0", instr_a, 32'hAABBCC00);
        chk("load2_wc", wc_a, 9'd1);

        // Stray valid while idle, then a gapped load watched at address 1.
        drive(0, 1'b0, 1'b1, 8'h55, 1'b1);
        @(negedge clock);
        drive(0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("idle_ignores_valid", busy_a, 1'b0);
        address_a = 8'h01;
        q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        load(0, q, 1);
        wait_idle(0, "load3_idle");
        chk("gap_first_idle", instr_a, 32'h9ABCDEF0);
        @(negedge clock);
        chk("gap_w1", instr_a, 32'h05060708);
        chk("load3_wc", wc_a, 9'd2);
        fetch(0, 0, d); chk("gap_w0", d, 32'h01020304);

        // Reset in the middle of a load, colliding with start and valid.
        drive(0, 1'b1, 1'b0, 8'h00, 1'b0);
        @(negedge clock);
        drive(0, 1'b0, 1'b1, 8'h11, 1'b0); @(negedge clock);
        drive(0, 1'b0, 1'b1, 8'h22, 1'b0); @(negedge clock);
        reset = 1'b1;
        drive(0, 1'b1, 1'b1, 8'h33, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        drive(0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("midrst_ready", ready_a, 1'b0);
        count_clear(n);
        chk("midrst_clear_cycles", n, 256);
        chk("midrst_ready_idle", ready_a, 1'b0);
        fetch(0, 0, d); chk("midrst_w0", d, 32'h0);
        fetch(0, 1, d); chk("midrst_w1", d, 32'h0);

        // Overflow on the 4-word instance: five words streamed.
        wait_idle(1, "b_ready_idle");
        q.delete();
        for (int i = 1; i <= 20; i++) q.push_back(8'(i));
        load(1, q, 0);
        wait_idle(1, "b_load_idle");
        chk("ovf_wc", wc_b, 3'd4); chk("ovf_err", err_b, 1'b1);
        fetch(1, 0, d); chk("ovf_w0", d, 32'h01020304);
        fetch(1, 3, d); chk("ovf_w3", d, 32'h0D0E0F10);
        drive(1, 1'b1, 1'b0, 8'h00, 1'b0);
        @(negedge clock);
        drive(1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("ovf_err_cleared", err_b, 1'b0); chk("ovf_ready", ready_b, 1'b1);
        drive(1, 1'b0, 1'b1, 8'h99, 1'b1);
        @(negedge clock);
        drive(1, 1'b0, 1'b0, 8'h00, 1'b0);
        wait_idle(1, "b_flush_idle");
        chk("b_wc1", wc_b, 3'd1);
        fetch(1, 0, d); chk("b_w0", d, 32'h99000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
